// File: rtl/motoro3_pkg.sv
// motoro3_pkg: constants and FSM encoding shared by the step sequencer and
// the PWM generator's step decodes.
//   m3State_t  sequencer FSM state encoding
//   STEP_NUM   steps per electrical cycle
//   IDLE_STEP  sgStep value while not sequencing (generator decodes as no-active)
//   MIN_LEN    minimum step length in clocks
package motoro3_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        RUN       = 2'd2,
        STOP_PEND = 2'd3
    } m3State_t;

    localparam int         STEP_NUM  = 12;
    localparam logic [3:0] IDLE_STEP = 4'd15;
    localparam int         MIN_LEN   = 4;

endpackage

// File: rtl/motoro3_step_cnt.sv
// motoro3_step_cnt: per-step clock counter with step-length latch/clamp,
// position-increment latch and registered boundary strobes.
// All flops update on negedge clk; nRst is asynchronous, active-low.
// Ports:
//   clk, nRst     clock / reset
//   start         sequencing begins on this edge (LOAD -> RUN)
//   stay          sequencing continues across this edge
//   stepLen       programmed step length (clamped to MIN_LEN when latched)
//   lenPosIn      programmed position increment
//   m3cnt         clock index within the current step
//   pwmLENpos     increment latched for the current step
//   first2/first1/last2/last1  strobes for m3cnt == 0 / 1 / len-2 / len-1
//   wrap          current clock is the last of the step
module motoro3_step_cnt
    import motoro3_pkg::*;
#(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic             stay,
    input  logic [CNT_W-1:0] stepLen,
    input  logic [15:0]      lenPosIn,
    output logic [CNT_W-1:0] m3cnt,
    output logic [15:0]      pwmLENpos,
    output logic             first2,
    output logic             first1,
    output logic             last2,
    output logic             last1,
    output logic             wrap
);

    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] lenClamped;
    logic [CNT_W-1:0] cntNext;
    logic [CNT_W-1:0] lenNext;
    logic [15:0]      posNext;
    logic             act;

    // last1 is only ever set while sequencing, so it doubles as the wrap flag.
    assign wrap = last1;

    always_comb begin
        lenClamped = (stepLen < CNT_W'(MIN_LEN)) ? CNT_W'(MIN_LEN) : stepLen;
        act        = start | stay;
        // Leaving the sequence puts everything back to its reset value.
        cntNext    = '0;
        lenNext    = CNT_W'(MIN_LEN);
        posNext    = '0;
        if (start) begin
            lenNext = lenClamped;
            posNext = lenPosIn;
        end else if (stay) begin
            if (last1) begin
                // Config is only sampled here, so a step never mixes settings.
                lenNext = lenClamped;
                posNext = lenPosIn;
            end else begin
                cntNext = m3cnt + CNT_W'(1);
                lenNext = len;
                posNext = pwmLENpos;
            end
        end
    end

    // Strobes decode the next-state count so they line up with m3cnt.
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            m3cnt     <= '0;
            len       <= CNT_W'(MIN_LEN);
            pwmLENpos <= '0;
            first2    <= 1'b0;
            first1    <= 1'b0;
            last2     <= 1'b0;
            last1     <= 1'b0;
        end else begin
            m3cnt     <= cntNext;
            len       <= lenNext;
            pwmLENpos <= posNext;
            first2    <= act && (cntNext == CNT_W'(0));
            first1    <= act && (cntNext == CNT_W'(1));
            last2     <= act && (cntNext == lenNext - CNT_W'(2));
            last1     <= act && (cntNext == lenNext - CNT_W'(1));
        end
    end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer: 12-step commutation sequencer feeding
// motoro3_pwm_generator. Runs the IDLE/LOAD/RUN/STOP_PEND FSM, the step
// index and the electrical-cycle counter; the per-step counter, length clamp
// and strobes live in motoro3_step_cnt.
// All flops update on negedge clk; nRst is asynchronous, active-low.
// Ports:
//   clk, nRst                     clock / reset
//   m3r_run                       1 = run, 0 = stop at end of step 11
//   m3r_stepLen, m3r_pwmLENpos    step config, latched at step boundaries
//   pwmActive1                    high while sequencing
//   sgStep                        current step 0..11, or IDLE_STEP
//   m3cnt                         clock index within the step
//   m3cntFirst2/First1/Last2/Last1  step-boundary strobes
//   pwmLENpos                     latched increment for the current step
//   cycleCnt                      completed electrical cycles (wraps)
//   busy                          FSM not idle
//   dbgState                      FSM state (m3State_t encoding)
module motoro3_step_sequencer
    import motoro3_pkg::*;
#(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             m3r_run,
    input  logic [CNT_W-1:0] m3r_stepLen,
    input  logic [15:0]      m3r_pwmLENpos,
    output logic             pwmActive1,
    output logic [3:0]       sgStep,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntFirst2,
    output logic             m3cntFirst1,
    output logic             m3cntLast2,
    output logic             m3cntLast1,
    output logic [15:0]      pwmLENpos,
    output logic [15:0]      cycleCnt,
    output logic             busy,
    output logic [1:0]       dbgState
);

    m3State_t state;
    m3State_t nextState;
    logic     curActive;
    logic     nextActive;
    logic     start;
    logic     stay;
    logic     wrap;
    logic     lastStep;

    assign lastStep = (sgStep == 4'(STEP_NUM - 1));
    assign busy     = (state != IDLE);
    assign dbgState = state;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (m3r_run) nextState = LOAD;
            LOAD:      nextState = m3r_run ? RUN : IDLE;
            RUN:       if (!m3r_run) nextState = STOP_PEND;
            STOP_PEND: begin
                // A re-asserted run wins, even on the final boundary.
                if (m3r_run)               nextState = RUN;
                else if (wrap && lastStep) nextState = IDLE;
            end
            default:   nextState = IDLE;
        endcase
        curActive  = (state == RUN) || (state == STOP_PEND);
        nextActive = (nextState == RUN) || (nextState == STOP_PEND);
        start      = (state == LOAD) && nextActive;
        stay       = curActive && nextActive;
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            sgStep     <= IDLE_STEP;
            pwmActive1 <= 1'b0;
            cycleCnt   <= '0;
        end else begin
            state      <= nextState;
            pwmActive1 <= nextActive;
            if (start) begin
                sgStep <= 4'd0;
            end else if (stay) begin
                if (wrap) sgStep <= lastStep ? 4'd0 : sgStep + 4'd1;
            end else begin
                sgStep <= IDLE_STEP;
            end
            // Counts on the final boundary whether or not a stop follows it.
            if (curActive && wrap && lastStep) cycleCnt <= cycleCnt + 16'd1;
        end
    end

    motoro3_step_cnt #(
        .CNT_W (CNT_W)
    ) uStepCnt (
        .clk       (clk),
        .nRst      (nRst),
        .start     (start),
        .stay      (stay),
        .stepLen   (m3r_stepLen),
        .lenPosIn  (m3r_pwmLENpos),
        .m3cnt     (m3cnt),
        .pwmLENpos (pwmLENpos),
        .first2    (m3cntFirst2),
        .first1    (m3cntFirst1),
        .last2     (m3cntLast2),
        .last1     (m3cntLast1),
        .wrap      (wrap)
    );

endmodule
